sc_apc_layer_seq: RTL and testbench
===================================

Name: sc_apc_layer_seq

Overview:
- Parametrised stochastic-computing fully-connected layer: N_OUT neurons in parallel, each an XNOR (bipolar multiply) array, an approximate parallel counter (APC) and a saturating stanh up/down counter.
- Runs one frame of LEN = 2^LOG_LEN bit-slices under a start/valid/ready handshake, counts the ones in each neuron's output stream, then sequentially scans for the argmax class.
- Successor to the fixed two-layer digit network: generalised widths, explicit frame control, a classifier result; layers chain via dout/dout_valid.

Parameters:
- N_IN, 32, input bitstreams per neuron (>=2)
- N_OUT, 10, neurons / classes (>=2)
- LOG_LEN, 8, frame length LEN = 2^LOG_LEN bit-slices
- NSTATE, 16, stanh counter states (power of 2, >=4)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin frame (honoured in IDLE only)
- busy  out  1  high in RUN or SCAN
- in_valid  in  1  bit-slice on din valid
- in_ready  out  1  high only in RUN
- din  in  N_IN  one bit of each input stream
- weight  in  [N_OUT] x N_IN  weight bitstream bits per neuron, sampled with din
- dout_valid  out  1  dout carries a new bit-slice
- dout  out  N_OUT  output stream bit per neuron
- done  out  1  one-cycle pulse, class result ready
- class_idx  out  clog2(N_OUT)  argmax neuron index
- class_score  out  LOG_LEN+1  ones count of the winning neuron

Behaviour:
- Reset (reset=0, async): FSM=IDLE; bit counter, accumulators, dout, dout_valid, done, busy, in_ready, class_idx, class_score = 0; stanh states = NSTATE/2.
- FSM IDLE -> RUN on start:
  - clear accumulators and bit counter;
  - stanh states = NSTATE/2;
  - class_idx/class_score keep their previous values until the next SCAN writes them.
- RUN, beat = in_valid & in_ready:
  - p_j = popcount(~(din ^ weight[j])), width clog2(N_IN+1).
  - s_j = 2*p_j - N_IN (signed).
  - state_j <= sat(state_j + s_j, 0, NSTATE-1).
  - dout[j] <= (next state_j >= NSTATE/2).
  - acc_j += that same bit.
  - dout_valid <= 1 for exactly one cycle per beat (latency 1).
  - No beat: everything holds, dout_valid <= 0.
- Beat with bit counter = LEN-1 -> SCAN. acc_j saturates at LEN and never wraps; width LOG_LEN+1.
- SCAN:
  - one index per cycle, 0..N_OUT-1; best updated only on strictly greater acc, so ties go to the lowest index;
  - exactly N_OUT cycles, then class_idx/class_score registered, done=1 for one cycle, FSM -> IDLE.
  - If the last beat is accepted in cycle t, done is high in cycle t+N_OUT+1.
- start in RUN/SCAN: ignored. start with done: ignored (FSM is DONE->IDLE that edge); accepted the next cycle.
- in_valid in IDLE/SCAN: ignored, no state change.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded.

Optional Feature:
- Macro SC_BIAS_EN.
- Defined:
  - extra input port bias [N_OUT] x 1, sampled on each beat;
  - APC counts N_IN+1 inputs (bias bit added directly, no XNOR);
  - s_j = 2*p_j - (N_IN+1).
- Undefined: no bias port; behaviour as above.

Decomposition:
- Package sc_nn_pkg: FSM enum (IDLE, RUN, SCAN), clog2-based width localparam helpers, the signed step type.
- Sub-module sc_apc_popcount (N_IN-input popcount plus signed-step output), instantiated once per neuron. The stanh counter and accumulator stay inline.

Test Plan:
Parameters for all tests: N_IN=4, N_OUT=3, LOG_LEN=3, NSTATE=8.
- Reset: assert reset=0 mid-clock -> all outputs 0 immediately, in_ready=0, class_idx=0.
- Frame, continuous in_valid, 8 beats, din=4'b1010:
  - weights: w0 = ~din, w1 = din, w2 = 4'b1001 (p=2, s=0);
  - stanh states: n0 -> 0, n1 -> 7, n2 stays 4;
  - dout = 3'b110 from beat 1 on (n2 >= 4 gives 1, n1 gives 1, n0 gives 0);
  - acc = {8,8,0}; class_idx=1 (tie with n2 goes to the lower index), class_score=8;
  - done 4 cycles after the last beat.
- Ties: all three weights identical -> class_idx=0.
- Gaps: in_valid toggles 1,0,1,0… -> dout_valid only after accepted beats; done only after 8 accepted beats; states unchanged during gaps.
- Reset and start mid-frame:
  - start pulsed during RUN -> bit counter not cleared, frame ends on schedule;
  - reset after 3 beats -> IDLE, a new start needs 8 full beats.
- SC_BIAS_EN build: din = weight (p=5), bias[0]=0 -> s0=+3, s1,s2=+5 -> stanh states saturate at 7.

Source files
------------

// File: rtl/sc_nn_pkg.sv
// sc_nn_pkg: shared FSM encoding, signed step type and width helpers for the
// stochastic-computing fully-connected layer (sc_apc_layer_seq).
package sc_nn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SCAN = 2'd2
    } fsm_e;

    // Wide enough for 2*N - N for any practical input count.
    localparam int STEP_W = 16;
    typedef logic signed [STEP_W-1:0] step_t;

    // Bits needed to hold a count in the range 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sc_apc_popcount.sv
// sc_apc_popcount: approximate parallel counter for one neuron. Counts the
// ones among N_BITS product bits and converts the count into the bipolar
// step 2*count - N_BITS that drives the stanh counter.
module sc_apc_popcount
    import sc_nn_pkg::*;
#(
    parameter int N_BITS = 32,
    parameter int CW     = cnt_w(N_BITS)
) (
    input  logic [N_BITS-1:0] bits_in,
    output logic [CW-1:0]     count,
    output step_t             step
);

    // Ones count of the product bits and the signed bipolar step derived from it.
    always_comb begin
        count = '0;
        for (int i = 0; i < N_BITS; i++) begin
            count = count + CW'(bits_in[i]);
        end
        step = (step_t'(count) <<< 1) - step_t'(N_BITS);
    end

endmodule

// File: rtl/sc_apc_layer_seq.sv
// sc_apc_layer_seq: stochastic-computing fully-connected layer with N_OUT
// parallel neurons (XNOR multiply, APC, saturating stanh counter), frame
// control over LEN = 2^LOG_LEN bit-slices and a sequential argmax scan.
// Optional feature: define SC_BIAS_EN to add a per-neuron bias bit that is
// fed straight into each APC as one extra input.
module sc_apc_layer_seq
    import sc_nn_pkg::*;
#(
    parameter int N_IN    = 32,
    parameter int N_OUT   = 10,
    parameter int LOG_LEN = 8,
    parameter int NSTATE  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_IN-1:0]            din,
    input  logic [N_IN-1:0]            weight [N_OUT],
`ifdef SC_BIAS_EN
    input  logic [N_OUT-1:0]           bias,
`endif
    output logic                       dout_valid,
    output logic [N_OUT-1:0]           dout,
    output logic                       done,
    output logic [$clog2(N_OUT)-1:0]   class_idx,
    output logic [LOG_LEN:0]           class_score
);

    localparam int SW    = $clog2(NSTATE);
    localparam int IDX_W = $clog2(N_OUT);
    localparam int ACC_W = LOG_LEN + 1;
    localparam int LEN   = 1 << LOG_LEN;
`ifdef SC_BIAS_EN
    localparam int APC_N = N_IN + 1;
`else
    localparam int APC_N = N_IN;
`endif
    localparam int CW    = cnt_w(APC_N);

    localparam logic [SW-1:0]            ST_MID   = SW'(NSTATE / 2);
    localparam logic [SW-1:0]            ST_TOP   = SW'(NSTATE - 1);
    localparam logic signed [STEP_W:0]   SUM_ZERO = '0;
    localparam logic signed [STEP_W:0]   SUM_TOP  = (STEP_W + 1)'(NSTATE - 1);
    localparam logic [ACC_W-1:0]         ACC_MAX  = ACC_W'(LEN);
    localparam logic [IDX_W-1:0]         IDX_LAST = IDX_W'(N_OUT - 1);

    fsm_e                 fsm_q, fsm_d;
    logic [LOG_LEN-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]        st_q [N_OUT];
    logic [SW-1:0]        st_d [N_OUT];
    logic [SW-1:0]        st_next [N_OUT];
    logic [ACC_W-1:0]     acc_q [N_OUT];
    logic [ACC_W-1:0]     acc_d [N_OUT];
    logic [N_OUT-1:0]     dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 in_ready_q, in_ready_d;
    logic [IDX_W-1:0]     scan_idx_q, scan_idx_d;
    logic [IDX_W-1:0]     best_idx_q, best_idx_d;
    logic [ACC_W-1:0]     best_score_q, best_score_d;
    logic [IDX_W-1:0]     class_idx_q, class_idx_d;
    logic [ACC_W-1:0]     class_score_q, class_score_d;
    logic [ACC_W-1:0]     cand;
    logic                 beat;
    step_t                step_w [N_OUT];

    assign beat = in_valid & in_ready_q;

    // Per neuron: XNOR products, APC step, and the saturated next stanh state.
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_neuron
        logic [APC_N-1:0]        apc_bits;
        logic [CW-1:0]           unused_count;
        logic signed [STEP_W:0]  sum;

`ifdef SC_BIAS_EN
        assign apc_bits = {bias[gi], ~(din ^ weight[gi])};
`else
        assign apc_bits = ~(din ^ weight[gi]);
`endif

        sc_apc_popcount #(
            .N_BITS (APC_N)
        ) u_apc (
            .bits_in (apc_bits),
            .count   (unused_count),
            .step    (step_w[gi])
        );

        assign sum = $signed({{(STEP_W + 1 - SW){1'b0}}, st_q[gi]})
                   + $signed({step_w[gi][STEP_W-1], step_w[gi]});
        assign st_next[gi] = (sum < SUM_ZERO) ? '0 :
                             (sum > SUM_TOP)  ? ST_TOP : sum[SW-1:0];
    end

    // Frame control, neuron state update and sequential argmax scan.
    always_comb begin
        fsm_d         = fsm_q;
        bit_cnt_d     = bit_cnt_q;
        st_d          = st_q;
        acc_d         = acc_q;
        dout_d        = dout_q;
        dout_valid_d  = 1'b0;
        done_d        = 1'b0;
        busy_d        = busy_q;
        in_ready_d    = in_ready_q;
        scan_idx_d    = scan_idx_q;
        best_idx_d    = best_idx_q;
        best_score_d  = best_score_q;
        class_idx_d   = class_idx_q;
        class_score_d = class_score_q;
        cand          = acc_q[scan_idx_q];

        case (fsm_q)
            IDLE: begin
                // A start coinciding with the done pulse is dropped.
                if (start && !done_q) begin
                    fsm_d      = RUN;
                    bit_cnt_d  = '0;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b1;
                    for (int j = 0; j < N_OUT; j++) begin
                        st_d[j]  = ST_MID;
                        acc_d[j] = '0;
                    end
                end
            end
            RUN: begin
                if (beat) begin
                    dout_valid_d = 1'b1;
                    bit_cnt_d    = bit_cnt_q + LOG_LEN'(1);
                    for (int j = 0; j < N_OUT; j++) begin
                        st_d[j]   = st_next[j];
                        dout_d[j] = (st_next[j] >= ST_MID);
                        if (dout_d[j] && (acc_q[j] != ACC_MAX)) begin
                            acc_d[j] = acc_q[j] + ACC_W'(1);
                        end
                    end
                    if (&bit_cnt_q) begin
                        fsm_d      = SCAN;
                        in_ready_d = 1'b0;
                        scan_idx_d = '0;
                    end
                end
            end
            SCAN: begin
                // Strictly-greater update keeps the lowest index on ties.
                if ((scan_idx_q == '0) || (cand > best_score_q)) begin
                    best_idx_d   = scan_idx_q;
                    best_score_d = cand;
                end
                scan_idx_d = scan_idx_q + IDX_W'(1);
                if (scan_idx_q == IDX_LAST) begin
                    class_idx_d   = best_idx_d;
                    class_score_d = best_score_d;
                    done_d        = 1'b1;
                    busy_d        = 1'b0;
                    fsm_d         = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q         <= IDLE;
            bit_cnt_q     <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            in_ready_q    <= 1'b0;
            scan_idx_q    <= '0;
            best_idx_q    <= '0;
            best_score_q  <= '0;
            class_idx_q   <= '0;
            class_score_q <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                st_q[j]  <= ST_MID;
                acc_q[j] <= '0;
            end
        end else begin
            fsm_q         <= fsm_d;
            bit_cnt_q     <= bit_cnt_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            in_ready_q    <= in_ready_d;
            scan_idx_q    <= scan_idx_d;
            best_idx_q    <= best_idx_d;
            best_score_q  <= best_score_d;
            class_idx_q   <= class_idx_d;
            class_score_q <= class_score_d;
            st_q          <= st_d;
            acc_q         <= acc_d;
        end
    end

    assign busy        = busy_q;
    assign in_ready    = in_ready_q;
    assign dout_valid  = dout_valid_q;
    assign dout        = dout_q;
    assign done        = done_q;
    assign class_idx   = class_idx_q;
    assign class_score = class_score_q;

endmodule

// File: tb/tb_sc_apc_layer_seq.sv
// tb_sc_apc_layer_seq: directed bench for sc_apc_layer_seq with a behavioural
// reference model feeding scoreboards for the dout stream and class results.
// Builds with or without SC_BIAS_EN.
module tb_sc_apc_layer_seq;

    localparam int N_IN    = 4;
    localparam int N_OUT   = 3;
    localparam int LOG_LEN = 3;
    localparam int NSTATE  = 8;
    localparam int LEN     = 1 << LOG_LEN;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      start;
    logic                      busy;
    logic                      in_valid;
    logic                      in_ready;
    logic [N_IN-1:0]           din;
    logic [N_IN-1:0]           weight [N_OUT];
`ifdef SC_BIAS_EN
    logic [N_OUT-1:0]          bias;
`endif
    logic                      dout_valid;
    logic [N_OUT-1:0]          dout;
    logic                      done;
    logic [$clog2(N_OUT)-1:0]  class_idx;
    logic [LOG_LEN:0]          class_score;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state (0 = idle, 1 = run, 2 = scan).
    int               m_fsm;
    int               m_beats;
    int               m_scan;
    int               m_st  [N_OUT];
    int               m_acc [N_OUT];
    logic [N_OUT-1:0] m_dout;
    bit               m_dv;
    bit               m_done;
    int               m_cls_idx;
    int               m_cls_score;

    logic [N_OUT-1:0] dout_sb [$];
    int               cls_sb  [$];

    sc_apc_layer_seq #(
        .N_IN    (N_IN),
        .N_OUT   (N_OUT),
        .LOG_LEN (LOG_LEN),
        .NSTATE  (NSTATE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .din         (din),
        .weight      (weight),
`ifdef SC_BIAS_EN
        .bias        (bias),
`endif
        .dout_valid  (dout_valid),
        .dout        (dout),
        .done        (done),
        .class_idx   (class_idx),
        .class_score (class_score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fsm = 0; m_beats = 0; m_scan = 0;
        m_dout = '0; m_dv = 0; m_done = 0;
        m_cls_idx = 0; m_cls_score = 0;
        for (int j = 0; j < N_OUT; j++) begin
            m_st[j]  = NSTATE / 2;
            m_acc[j] = 0;
        end
        dout_sb.delete();
        cls_sb.delete();
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_edge();
        bit nd;
        int p, s, v, best;
        nd   = 0;
        m_dv = 0;
        case (m_fsm)
            0: if (start && !m_done) begin
                m_fsm = 1; m_beats = 0;
                for (int j = 0; j < N_OUT; j++) begin
                    m_st[j]  = NSTATE / 2;
                    m_acc[j] = 0;
                end
            end
            1: if (in_valid) begin
                for (int j = 0; j < N_OUT; j++) begin
                    p = 0;
                    for (int k = 0; k < N_IN; k++) if (din[k] === weight[j][k]) p++;
`ifdef SC_BIAS_EN
                    p = p + int'(bias[j]);
                    s = 2 * p - (N_IN + 1);
`else
                    s = 2 * p - N_IN;
`endif
                    v = m_st[j] + s;
                    if (v < 0) v = 0;
                    if (v > NSTATE - 1) v = NSTATE - 1;
                    m_st[j]   = v;
                    m_dout[j] = (v >= NSTATE / 2);
                    if (m_dout[j] && m_acc[j] < LEN) m_acc[j]++;
                end
                dout_sb.push_back(m_dout);
                m_dv = 1;
                m_beats++;
                if (m_beats == LEN) begin
                    m_fsm = 2; m_scan = 0;
                end
            end
            2: begin
                m_scan++;
                if (m_scan == N_OUT) begin
                    best = 0;
                    for (int j = 1; j < N_OUT; j++) if (m_acc[j] > m_acc[best]) best = j;
                    m_cls_idx   = best;
                    m_cls_score = m_acc[best];
                    cls_sb.push_back((best << 16) | m_acc[best]);
                    nd    = 1;
                    m_fsm = 0;
                end
            end
            default: m_fsm = 0;
        endcase
        m_done = nd;
    endtask

    task automatic check_outputs();
        logic [N_OUT-1:0] exp_d;
        int               exp_c;
        chk("busy", busy, m_fsm != 0);
        chk("in_ready", in_ready, m_fsm == 1);
        chk("dout_valid", dout_valid, m_dv);
        chk("dout_hold", dout, m_dout);
        chk("done", done, m_done);
        chk("class_idx_hold", class_idx, m_cls_idx);
        chk("class_score_hold", class_score, m_cls_score);
        if (dout_valid === 1'b1) begin
            chk("dout_sb_nonempty", dout_sb.size() > 0, 1);
            if (dout_sb.size() > 0) begin
                exp_d = dout_sb.pop_front();
                chk("dout_sb", dout, exp_d);
            end
        end
        if (done === 1'b1) begin
            chk("cls_sb_nonempty", cls_sb.size() > 0, 1);
            if (cls_sb.size() > 0) begin
                exp_c = cls_sb.pop_front();
                chk("cls_sb_idx", class_idx, exp_c >> 16);
                chk("cls_sb_score", class_score, exp_c & 16'hFFFF);
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic set_w(input logic [N_IN-1:0] w0, input logic [N_IN-1:0] w1,
                         input logic [N_IN-1:0] w2);
        weight[0] = w0; weight[1] = w1; weight[2] = w2;
    endtask

    task automatic start_frame();
        start = 1'b1;
        for (int c = 0; c < 3 && m_fsm != 1; c++) tick();
        start = 1'b0;
        chk("frame_started", busy, 1);
    endtask

    // mode 0: continuous valid; 1: valid alternates 1,0; 2: random valid and din.
    task automatic run_beats(input int n, input int mode);
        int got;
        got = 0;
        for (int c = 0; c < 200 && got < n; c++) begin
            case (mode)
                1:       in_valid = (c % 2 == 0);
                2: begin in_valid = 1'($urandom_range(0, 1)); din = N_IN'($urandom); end
                default: in_valid = 1'b1;
            endcase
            if (m_fsm == 1 && in_valid) got++;
            tick();
        end
        in_valid = 1'b0;
        chk("beats_accepted", got, n);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic async_reset_check();
        #4;
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        #1;
        model_reset();
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_dout_valid", dout_valid, 0);
        chk("arst_dout", dout, 0);
        chk("arst_done", done, 0);
        chk("arst_class_idx", class_idx, 0);
        chk("arst_class_score", class_score, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int cyc;
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        din      = '0;
        set_w('0, '0, '0);
`ifdef SC_BIAS_EN
        bias     = '0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_done", done, 0);
        chk("rst_class_idx", class_idx, 0);
        chk("rst_class_score", class_score, 0);
        reset = 1'b1;
        tick();

        // Frame 1: n0 anti-correlated, n1 correlated, n2 neutral.
        din = 4'b1010;
        set_w(4'b0101, 4'b1010, 4'b1001);
        start_frame();
        in_valid = 1'b1;
        for (int b = 0; b < LEN; b++) begin
            tick();
            chk("f1_dout", dout, 3'b110);
        end
        in_valid = 1'b0;
        wait_done(cyc);
        chk("f1_done_latency", cyc, N_OUT);
        chk("f1_class_idx", class_idx, 1);
        chk("f1_class_score", class_score, 8);

        // Frame 2: identical weights tie; start held during the done cycle.
        set_w(4'b1100, 4'b1100, 4'b1100);
        start = 1'b1;
        tick();
        chk("start_at_done_ignored", busy, 0);
        tick();
        chk("start_after_done_taken", busy, 1);
        start = 1'b0;
        run_beats(LEN, 0);
        wait_done(cyc);
        chk("tie_class_idx", class_idx, 0);
        chk("tie_class_score", class_score, 8);

        // Frame 3: in_valid alternating, beats only on accepted slices.
        set_w(4'b0101, 4'b1000, 4'b1010);
        tick();
        start_frame();
        run_beats(LEN, 1);
        wait_done(cyc);
        chk("gap_class_idx", class_idx, 1);
        chk("gap_class_score", class_score, 8);

        // Frame 4: start pulsed mid-RUN must not restart the frame.
        tick();
        start_frame();
        run_beats(3, 0);
        start    = 1'b1;
        in_valid = 1'b1;
        tick();
        start    = 1'b0;
        run_beats(LEN - 4, 0);
        wait_done(cyc);
        chk("midstart_done_latency", cyc, N_OUT);

        // Frame 5: reset after 3 beats, then a full fresh random frame.
        tick();
        start_frame();
        run_beats(3, 0);
        async_reset_check();
        tick();
        chk("post_reset_idle", busy, 0);
        start_frame();
        run_beats(LEN, 2);
        wait_done(cyc);

`ifdef SC_BIAS_EN
        // Bias frame: din equals every weight; bias drives all states to the top.
        tick();
        din  = 4'b1010;
        set_w(4'b1010, 4'b1010, 4'b1010);
        bias = 3'b110;
        start_frame();
        run_beats(LEN, 0);
        chk("bias_dout", dout, 3'b111);
        wait_done(cyc);
        chk("bias_class_idx", class_idx, 0);
        chk("bias_class_score", class_score, 8);
`endif

        tick();
        chk("dout_sb_drained", dout_sb.size(), 0);
        chk("cls_sb_drained", cls_sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
